// File: rtl/mac16_frame_serializer.sv
// Ping-pong double buffer that accepts a whole N_WORDS-word frame in one transfer
// and unloads it one word per cycle over a valid/ready stream.
module mac16_frame_serializer #(
    parameter int  DATA_W  = 32,
    parameter int  N_WORDS = 16,
    parameter int  ORDER   = 0,
    localparam int IDX_W   = $clog2(N_WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_WORDS*DATA_W-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [DATA_W-1:0]    out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [IDX_W-1:0]            out_index,
    output logic                        busy,
    output logic [15:0]                 frames_out
);

    logic [N_WORDS*DATA_W-1:0] r_buf [2];
    logic [1:0]                r_occ;
    logic                      r_wr_ptr;
    logic                      r_rd_ptr;
    logic                      r_run;
    logic [IDX_W-1:0]          r_idx;
    logic [15:0]               r_frames;

    logic                      w_load;
    logic                      w_xfer;
    logic                      w_done;
    logic [IDX_W-1:0]          w_word;
    logic [N_WORDS*DATA_W-1:0] w_frame;

    // r_run keeps in_ready low for as long as reset is held, from registered state only
    assign in_ready   = r_run & ~r_occ[r_wr_ptr];
    assign out_valid  = r_occ[r_rd_ptr];
    assign busy       = |r_occ;
    assign frames_out = r_frames;

    assign w_load = in_valid & in_ready;
    assign w_xfer = out_valid & out_ready;
    assign w_done = w_xfer & out_last;

    // N_WORDS is a power of two, so N_WORDS-1-idx is just the bitwise inverse
    assign w_word  = (ORDER != 0) ? ~r_idx : r_idx;
    assign w_frame = r_buf[r_rd_ptr];

    assign out_data  = out_valid ? w_frame[int'(w_word)*DATA_W +: DATA_W] : '0;
    assign out_last  = out_valid & (r_idx == IDX_W'(N_WORDS - 1));
    assign out_index = out_valid ? r_idx : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_occ    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_run    <= 1'b0;
            r_idx    <= '0;
            r_frames <= '0;
        end else begin
            r_run <= 1'b1;
            // load needs occ[wr]==0 and release needs occ[rd]==1, so they never hit the same buffer
            if (w_load) begin
                r_occ[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_done) begin
                r_occ[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= ~r_rd_ptr;
                r_idx           <= '0;
                r_frames        <= r_frames + 16'd1;
            end else if (w_xfer) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_mac16_frame_serializer.sv
// Bench for mac16_frame_serializer: a reset/single-frame vector table, directed multi-cycle
// sequences and a randomized run, all checked against a frame-queue reference model.
module tb_mac16_frame_serializer;

    localparam int DW = 32;
    localparam int NW = 16;
    localparam int IW = 4;
    localparam int FW = DW * NW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic [FW-1:0] in_data;

    logic          in_ready, out_valid, out_last, busy;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic [15:0]   frames_out;

    logic          in_ready_r, out_valid_r, out_last_r, busy_r;
    logic [DW-1:0] out_data_r;
    logic [IW-1:0] out_index_r;
    logic [15:0]   frames_out_r;

    always #5 clk = ~clk;

    mac16_frame_serializer #(.DATA_W(DW), .N_WORDS(NW), .ORDER(0)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_index(out_index), .busy(busy), .frames_out(frames_out)
    );

    mac16_frame_serializer #(.DATA_W(DW), .N_WORDS(NW), .ORDER(1)) u_dut_r (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
        .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready), .out_last(out_last_r),
        .out_index(out_index_r), .busy(busy_r), .frames_out(frames_out_r)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mkframe(input logic [DW-1:0] base);
        logic [FW-1:0] f;
        for (int i = 0; i < NW; i++) f[i*DW +: DW] = base + DW'(i);
        return f;
    endfunction

    function automatic logic [FW-1:0] rndframe();
        logic [FW-1:0] f;
        for (int i = 0; i < NW; i++) f[i*DW +: DW] = $urandom;
        return f;
    endfunction

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] base;
        logic          e_ir;
        logic          e_ov;
        logic          e_last;
        logic [IW-1:0] e_idx;
        logic [DW-1:0] e_dat;
        logic [DW-1:0] e_dat_r;
        logic          e_busy;
        logic [15:0]   e_frm;
    } vec_t;

    function automatic vec_t mkvec(input logic rst, input logic iv, input logic [DW-1:0] base,
                                   input logic ir, input logic ov, input logic last,
                                   input logic [IW-1:0] idx, input logic [DW-1:0] dat,
                                   input logic [DW-1:0] dat_r, input logic bsy,
                                   input logic [15:0] frm);
        vec_t v;
        v.rst = rst; v.iv = iv; v.base = base; v.e_ir = ir; v.e_ov = ov; v.e_last = last;
        v.e_idx = idx; v.e_dat = dat; v.e_dat_r = dat_r; v.e_busy = bsy; v.e_frm = frm;
        return v;
    endfunction

    // Reference model: queue of whole frames plus the send position inside the head frame
    logic [FW-1:0] m_q[$];
    int            m_pos   = 0;
    logic [15:0]   m_frm   = 16'd0;
    bit            m_run   = 1'b0;
    bit            m_known = 1'b0;
    bit            m_acc   = 1'b0;

    bit            s_ov, s_ir, s_last;
    logic [DW-1:0] s_dat;

    task automatic cycle();
        logic [FW-1:0] f;
        logic [DW-1:0] ed;
        logic [IW-1:0] eidx;
        logic          e_ir, e_ov, e_last;
        @(negedge clk);
        e_ov   = (m_q.size() > 0);
        e_ir   = m_run && (m_q.size() < 2);
        e_last = e_ov && (m_pos == NW - 1);
        ed     = '0;
        eidx   = '0;
        if (e_ov) begin
            f    = m_q[0];
            ed   = f[m_pos*DW +: DW];
            eidx = IW'(m_pos);
        end
        s_ov = out_valid; s_ir = in_ready; s_last = out_last; s_dat = out_data;
        if (m_known)
            chk("stream", {8'd0, in_ready, out_valid, out_last, out_index, out_data, busy, frames_out},
                          {8'd0, e_ir, e_ov, e_last, eidx, ed, e_ov, m_frm});
        m_acc = 1'b0;
        if (!reset) begin
            m_q.delete();
            m_pos = 0; m_frm = 16'd0; m_run = 1'b0; m_known = 1'b1;
        end else begin
            if (e_ov && out_ready) begin
                if (m_pos == NW - 1) begin
                    void'(m_q.pop_front());
                    m_pos = 0;
                    m_frm = m_frm + 16'd1;
                end else begin
                    m_pos++;
                end
            end
            if (in_valid && e_ir) begin
                m_q.push_back(in_data);
                m_acc = 1'b1;
            end
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        reset = 1'b0; in_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    vec_t tbl[21];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nsent, run, maxrun, tot, cnt;
        bit  saw_block, prevlast, done, holding, got_first;
        logic [DW-1:0] first_dat;

        tbl[0] = mkvec(0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mkvec(1, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mkvec(1, 1, 'h100,  1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NW; i++)
            tbl[3+i] = mkvec(1, 0, 0, 1, 1, (i == NW - 1), IW'(i), DW'('h100 + i), DW'('h10F - i), 1, 0);
        tbl[19] = mkvec(1, 0, 0,     1, 0, 0, 0, 0, 0, 0, 1);
        tbl[20] = mkvec(1, 0, 0,     1, 0, 0, 0, 0, 0, 0, 1);

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 21; r++) begin
            reset = tbl[r].rst; in_valid = tbl[r].iv; in_data = mkframe(tbl[r].base);
            @(negedge clk);
            chk($sformatf("tbl[%0d]", r),
                {8'd0, in_ready, out_valid, out_last, out_index, out_data, busy, frames_out},
                {8'd0, tbl[r].e_ir, tbl[r].e_ov, tbl[r].e_last, tbl[r].e_idx, tbl[r].e_dat,
                 tbl[r].e_busy, tbl[r].e_frm});
            chk($sformatf("tbl_rev[%0d]", r),
                {26'd0, out_valid_r, out_last_r, out_index_r, out_data_r},
                {26'd0, tbl[r].e_ov, tbl[r].e_last, tbl[r].e_idx, tbl[r].e_dat_r});
            @(posedge clk);
            #1;
        end

        // back-to-back streaming of three frames
        reset_seq();
        out_ready = 1'b1; in_valid = 1'b1; in_data = mkframe(0);
        nsent = 0; run = 0; maxrun = 0; tot = 0; saw_block = 0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (s_ov) begin run++; tot++; if (run > maxrun) maxrun = run; end
            else run = 0;
            if (in_valid && !s_ir) saw_block = 1;
            if (m_acc) begin
                nsent++;
                if (nsent < 3) in_data = mkframe(DW'(nsent * 'h100));
                else in_valid = 1'b0;
            end
        end
        chk("b2b_run", 64'(maxrun), 64'd48);
        chk("b2b_total", 64'(tot), 64'd48);
        chk("b2b_inready_drop", 64'(saw_block), 64'd1);
        chk("b2b_frames", 64'(frames_out), 64'd3);

        // backpressure 1,0,0,1
        reset_seq();
        in_valid = 1'b1; in_data = rndframe(); nsent = 0;
        for (int c = 0; c < 120; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            cycle();
            if (m_acc) begin
                nsent++;
                if (nsent < 3) in_data = rndframe();
                else in_valid = 1'b0;
            end
        end
        chk("bp_frames", 64'(frames_out), 64'd3);

        // both buffers full, third frame refused until the first drains
        reset_seq();
        out_ready = 1'b0; in_valid = 1'b1; in_data = mkframe('h300); nsent = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (m_acc) begin
                nsent++;
                in_data = mkframe((nsent == 1) ? DW'('h400) : DW'('h500));
            end
        end
        chk("full_inready", 64'(s_ir), 64'd0);
        chk("full_accepted", 64'(nsent), 64'd2);
        out_ready = 1'b1; prevlast = 0; done = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (prevlast && !done) begin
                chk("release_inready_next", 64'(s_ir), 64'd1);
                done = 1;
            end
            if (s_last && !done && !prevlast) begin
                chk("release_inready_same", 64'(s_ir), 64'd0);
                prevlast = 1;
            end
            if (m_acc) begin nsent++; in_valid = 1'b0; end
        end
        chk("full_third_loaded", 64'(nsent), 64'd3);

        // reset mid-frame with a second frame queued
        reset_seq();
        out_ready = 1'b1; in_valid = 1'b1; in_data = mkframe('hA00); nsent = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (m_acc) begin
                nsent++;
                if (nsent == 1) in_data = mkframe('hB00);
                else in_valid = 1'b0;
            end
            if (nsent == 2 && m_pos == 6 && m_q.size() == 2) break;
        end
        reset = 1'b0; in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        chk("midrst_valid", 64'(s_ov), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_frames", 64'(frames_out), 64'd0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin cycle(); if (s_ov) cnt++; end
        chk("midrst_no_stale", 64'(cnt), 64'd0);
        in_valid = 1'b1; in_data = mkframe('hC00); got_first = 0; first_dat = '0;
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (s_ov && !got_first) begin got_first = 1; first_dat = s_dat; end
            if (m_acc) in_valid = 1'b0;
        end
        chk("midrst_new_first", 64'(first_dat), 64'h0C00);

        // randomized traffic with occasional resets
        reset_seq();
        holding = 0;
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            if (!holding) begin
                in_valid = ($urandom_range(0, 2) != 0);
                if (in_valid) in_data = rndframe();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            holding = in_valid && !m_acc && reset;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
